// File: rtl/label_equiv_ctrl.sv
`timescale 1ns/1ps
// label_equiv_ctrl
// Equivalence-table controller for connected-domain labeling. Maintains
// parent[label] in an external simple dual-port RAM (0 = root), merges label
// pairs by linking the larger root under the smaller one, and on command
// flattens the table so each label points straight at its final root.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   merge_valid/ready        merge request handshake, labels merge_a/merge_b
//   flatten_start,num_labels start a flatten pass over labels 1..num_labels
//   busy, done               activity flag, one-cycle completion pulse
//   ram_wea/addra/data_a     RAM write port
//   ram_enb/addrb            RAM read port, ram_data_b valid one cycle later
module label_equiv_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             merge_valid,
  output logic             merge_ready,
  input  logic [WIDTH-1:0] merge_a,
  input  logic [WIDTH-1:0] merge_b,
  input  logic             flatten_start,
  input  logic [DEPTH-1:0] num_labels,
  output logic             busy,
  output logic             done,
  output logic             ram_wea,
  output logic [DEPTH-1:0] ram_addra,
  output logic [WIDTH-1:0] ram_data_a,
  output logic             ram_enb,
  output logic [DEPTH-1:0] ram_addrb,
  input  logic [WIDTH-1:0] ram_data_b
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FA_RD   = 4'd1,
    FA_CHK  = 4'd2,
    FB_RD   = 4'd3,
    FB_CHK  = 4'd4,
    LINK    = 4'd5,
    FL_RD1  = 4'd6,
    FL_CHK1 = 4'd7,
    FL_RD2  = 4'd8,
    FL_CHK2 = 4'd9,
    FL_WR   = 4'd10,
    DONE    = 4'd11
  } state_t;

  localparam logic [DEPTH-1:0] ONE_D  = DEPTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [DEPTH-1:0] ZERO_D = '0;

  state_t           state_q;
  logic [WIDTH-1:0] b_q;       // second merge label, walked after root_a is found
  logic [WIDTH-1:0] cur_q;     // label currently being followed up its chain
  logic [WIDTH-1:0] root_a_q;  // root of a during merge; resolved root during flatten
  logic [WIDTH-1:0] root_b_q;
  logic [WIDTH-1:0] par_q;     // parent of the label being flattened
  logic [DEPTH-1:0] lbl_q;     // label being flattened
  logic [DEPTH-1:0] num_q;     // last label of the flatten pass

  logic merge_noop;
  assign merge_noop = (merge_a == merge_b) || (merge_a == ZERO_W) || (merge_b == ZERO_W);

  // Flatten has priority over merges, so ready is withheld while it is requested.
  assign merge_ready = (state_q == IDLE) && !flatten_start && !rst;

  // Controller FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      b_q      <= ZERO_W;
      cur_q    <= ZERO_W;
      root_a_q <= ZERO_W;
      root_b_q <= ZERO_W;
      par_q    <= ZERO_W;
      lbl_q    <= ZERO_D;
      num_q    <= ZERO_D;
    end else begin
      case (state_q)
        IDLE: begin
          if (flatten_start) begin
            num_q <= num_labels;
            lbl_q <= ONE_D;
            state_q <= (num_labels == ZERO_D) ? DONE : FL_RD1;
          end else if (merge_valid) begin
            cur_q   <= merge_a;
            b_q     <= merge_b;
            state_q <= merge_noop ? IDLE : FA_RD;
          end else begin
            state_q <= IDLE;
          end
        end
        FA_RD: state_q <= FA_CHK;
        FA_CHK: begin
          if (ram_data_b == ZERO_W) begin
            root_a_q <= cur_q;
            cur_q    <= b_q;
            state_q  <= FB_RD;
          end else begin
            cur_q   <= ram_data_b;
            state_q <= FA_RD;
          end
        end
        FB_RD: state_q <= FB_CHK;
        FB_CHK: begin
          if (ram_data_b == ZERO_W) begin
            root_b_q <= cur_q;
            state_q  <= LINK;
          end else begin
            cur_q   <= ram_data_b;
            state_q <= FB_RD;
          end
        end
        LINK: state_q <= IDLE;
        FL_RD1: state_q <= FL_CHK1;
        FL_CHK1: begin
          if (ram_data_b != ZERO_W) begin
            par_q   <= ram_data_b;
            state_q <= FL_RD2;
          end else if (lbl_q == num_q) begin
            // Compare before incrementing so the top label never wraps.
            state_q <= DONE;
          end else begin
            lbl_q   <= lbl_q + ONE_D;
            state_q <= FL_RD1;
          end
        end
        FL_RD2: state_q <= FL_CHK2;
        FL_CHK2: begin
          // Lower labels are already flat, so the parent's parent is the root.
          root_a_q <= (ram_data_b == ZERO_W) ? par_q : ram_data_b;
          state_q  <= FL_WR;
        end
        FL_WR: begin
          if (lbl_q == num_q) begin
            state_q <= DONE;
          end else begin
            lbl_q   <= lbl_q + ONE_D;
            state_q <= FL_RD1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode of RAM strobes and status; forced low while reset is held so
  // an aborted write never reaches the RAM.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_wea    = 1'b0;
    ram_addra  = ZERO_D;
    ram_data_a = ZERO_W;
    ram_enb    = 1'b0;
    ram_addrb  = ZERO_D;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        FA_RD, FB_RD: begin
          ram_enb   = 1'b1;
          ram_addrb = cur_q[DEPTH-1:0];
        end
        LINK: begin
          if (root_a_q > root_b_q) begin
            ram_wea    = 1'b1;
            ram_addra  = root_a_q[DEPTH-1:0];
            ram_data_a = root_b_q;
          end else if (root_b_q > root_a_q) begin
            ram_wea    = 1'b1;
            ram_addra  = root_b_q[DEPTH-1:0];
            ram_data_a = root_a_q;
          end else begin
            ram_wea = 1'b0;  // already equivalent
          end
        end
        FL_RD1: begin
          ram_enb   = 1'b1;
          ram_addrb = lbl_q;
        end
        FL_RD2: begin
          ram_enb   = 1'b1;
          ram_addrb = par_q[DEPTH-1:0];
        end
        FL_WR: begin
          ram_wea    = 1'b1;
          ram_addra  = lbl_q;
          ram_data_a = root_a_q;
        end
        DONE: done = 1'b1;
        default: busy = (state_q != IDLE);
      endcase
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_label_equiv_ctrl.sv
`timescale 1ns/1ps
module tb_label_equiv_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       merge_valid = 1'b0;
  logic       merge_ready;
  logic [7:0] merge_a = 8'd0;
  logic [7:0] merge_b = 8'd0;
  logic       flatten_start = 1'b0;
  logic [7:0] num_labels = 8'd0;
  logic       busy, done, ram_wea, ram_enb;
  logic [7:0] ram_addra, ram_data_a, ram_addrb;
  logic [7:0] ram_data_b = 8'd0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  mem [0:255];
  logic [15:0] exp_wr_q [$];
  logic [15:0] exp_w;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] mask;
    int          wr;
    int          rdy;
    logic [15:0] w;
  } merge_case_t;

  merge_case_t mq [$];

  label_equiv_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .merge_valid(merge_valid), .merge_ready(merge_ready),
    .merge_a(merge_a), .merge_b(merge_b),
    .flatten_start(flatten_start), .num_labels(num_labels),
    .busy(busy), .done(done),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_data_a(ram_data_a),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_data_b(ram_data_b)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM with registered read port.
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_data_a;
    if (ram_enb) ram_data_b <= mem[ram_addrb];
  end

  // Write scoreboard: every RAM write must match the next expected one.
  always @(negedge clk) begin
    if (ram_wea === 1'b1) begin
      tests_run++;
      if (exp_wr_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wr_unexpected: got addr %0d data %0d, required no write", ram_addra, ram_data_a);
      end else begin
        exp_w = exp_wr_q.pop_front();
        if ({ram_addra, ram_data_a} !== exp_w) begin
          tests_failed++;
          $display("FAIL wr_value: got addr %0d data %0d, required addr %0d data %0d",
                   ram_addra, ram_data_a, exp_w[15:8], exp_w[7:0]);
        end
      end
    end
  end

  function automatic merge_case_t mk(input logic [7:0] a, input logic [7:0] b, input logic [31:0] mask,
                                     input int wr, input int rdy, input logic [7:0] wa, input logic [7:0] wd);
    merge_case_t c;
    c.a = a; c.b = b; c.mask = mask; c.wr = wr; c.rdy = rdy; c.w = {wa, wd};
    return c;
  endfunction

  // Issue one merge; report ready at accept, read-cycle mask, first write cycle, ready-return cycle.
  task automatic drive_merge(input logic [7:0] a, input logic [7:0] b, output logic rdy0,
                             output logic [31:0] rd_mask, output int wr_cyc, output int rdy_cyc);
    rd_mask = '0; wr_cyc = -1; rdy_cyc = -1;
    @(posedge clk); #1;
    merge_valid = 1'b1; merge_a = a; merge_b = b;
    @(negedge clk);
    rdy0 = merge_ready;
    for (int cyc = 1; cyc <= 20 && rdy_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      merge_valid = 1'b0;
      @(negedge clk);
      if (ram_enb === 1'b1) rd_mask[cyc] = 1'b1;
      if (ram_wea === 1'b1 && wr_cyc < 0) wr_cyc = cyc;
      if (merge_ready === 1'b1) rdy_cyc = cyc;
    end
  endtask

  // Start a flatten; report ready at start, done cycle/count, first idle cycle, strobe count.
  task automatic drive_flatten(input logic [7:0] num, input int budget, output logic rdy0,
                               output int done_cyc, output int done_cnt, output int idle_cyc, output int strobes);
    done_cyc = -1; done_cnt = 0; idle_cyc = -1; strobes = 0;
    @(posedge clk); #1;
    flatten_start = 1'b1; num_labels = num;
    @(negedge clk);
    rdy0 = merge_ready;
    for (int cyc = 1; cyc <= budget && idle_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      flatten_start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (ram_enb === 1'b1 || ram_wea === 1'b1) strobes++;
      if (busy === 1'b0) idle_cyc = cyc;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready} !== 28'd0) begin
        tests_failed++;
        $display("FAIL reset_hold: got outputs %h, required 0", {busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready} !== 28'd1) begin
      tests_failed++;
      $display("FAIL reset_release: got outputs %h, required 1 (only merge_ready)", {busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready});
    end
  endtask

  // Runs every merge queued in mq, in order.
  task automatic test_merges;
    logic rdy0; logic [31:0] mask; int wr, rdy;
    merge_case_t c;
    while (mq.size() > 0) begin
      c = mq.pop_front();
      if (c.wr >= 0) exp_wr_q.push_back(c.w);
      drive_merge(c.a, c.b, rdy0, mask, wr, rdy);
      tests_run++;
      if (rdy0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL merge_accept(%0d,%0d): got ready %b, required 1", c.a, c.b, rdy0);
      end
      tests_run++;
      if (mask !== c.mask) begin
        tests_failed++;
        $display("FAIL merge_reads(%0d,%0d): got read-cycle mask %h, required %h", c.a, c.b, mask, c.mask);
      end
      tests_run++;
      if (wr != c.wr) begin
        tests_failed++;
        $display("FAIL merge_wr_cycle(%0d,%0d): got %0d, required %0d", c.a, c.b, wr, c.wr);
      end
      tests_run++;
      if (rdy != c.rdy) begin
        tests_failed++;
        $display("FAIL merge_ready_cycle(%0d,%0d): got %0d, required %0d", c.a, c.b, rdy, c.rdy);
      end
    end
  endtask

  task automatic test_flatten_full;
    logic rdy0; int dc, dn, ic, st;
    exp_wr_q.push_back({8'd4, 8'd2});
    exp_wr_q.push_back({8'd5, 8'd3});
    exp_wr_q.push_back({8'd6, 8'd2});
    exp_wr_q.push_back({8'd7, 8'd3});
    drive_flatten(8'd8, 60, rdy0, dc, dn, ic, st);
    tests_run++;
    if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL flat_ready_block: got %b, required 0", rdy0); end
    tests_run++;
    if (dc != 29 || dn != 1) begin tests_failed++; $display("FAIL flat_done: got cycle %0d count %0d, required cycle 29 count 1", dc, dn); end
    tests_run++;
    if (ic != 30) begin tests_failed++; $display("FAIL flat_idle: got busy-low cycle %0d, required 30", ic); end
    tests_run++;
    if (mem[6] !== 8'd2 || mem[4] !== 8'd2 || mem[2] !== 8'd0) begin
      tests_failed++;
      $display("FAIL flat_table: got p6=%0d p4=%0d p2=%0d, required 2 2 0", mem[6], mem[4], mem[2]);
    end
    tests_run++;
    if (exp_wr_q.size() != 0) begin tests_failed++; $display("FAIL flat_writes_missing: got %0d pending, required 0", exp_wr_q.size()); end
  endtask

  task automatic test_flatten_empty;
    logic rdy0; int dc, dn, ic, st;
    drive_flatten(8'd0, 10, rdy0, dc, dn, ic, st);
    tests_run++;
    if (dc != 1 || dn != 1 || ic != 2) begin
      tests_failed++;
      $display("FAIL flat0_timing: got done cycle %0d count %0d idle %0d, required 1 1 2", dc, dn, ic);
    end
    tests_run++;
    if (st != 0) begin tests_failed++; $display("FAIL flat0_strobes: got %0d, required 0", st); end
  endtask

  task automatic test_reset_mid_flatten;
    logic rdy0; int dc, dn, ic, st;
    mq.push_back(mk(8'd9,  8'd8,  32'h0000_000A, 5, 6, 8'd9,  8'd8));
    mq.push_back(mk(8'd8,  8'd1,  32'h0000_000A, 5, 6, 8'd8,  8'd1));
    mq.push_back(mk(8'd11, 8'd10, 32'h0000_000A, 5, 6, 8'd11, 8'd10));
    mq.push_back(mk(8'd10, 8'd1,  32'h0000_000A, 5, 6, 8'd10, 8'd1));
    test_merges();
    // Label 9 reaches its write at cycle 36; reset lands on that cycle.
    exp_wr_q.push_back({8'd4, 8'd2});
    exp_wr_q.push_back({8'd5, 8'd3});
    exp_wr_q.push_back({8'd6, 8'd2});
    exp_wr_q.push_back({8'd7, 8'd3});
    exp_wr_q.push_back({8'd8, 8'd1});
    @(posedge clk); #1;
    flatten_start = 1'b1; num_labels = 8'd11;
    for (int cyc = 1; cyc <= 37; cyc++) begin
      @(posedge clk); #1;
      flatten_start = 1'b0;
      rst = (cyc == 36);
      @(negedge clk);
      if (cyc == 36) begin
        tests_run++;
        if ({busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready} !== 28'd0) begin
          tests_failed++;
          $display("FAIL midrst_hold: got outputs %h, required 0", {busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready});
        end
      end else if (cyc == 37) begin
        tests_run++;
        if ({busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready} !== 28'd1) begin
          tests_failed++;
          $display("FAIL midrst_idle: got outputs %h, required 1 (only merge_ready)", {busy, done, ram_wea, ram_enb, ram_addra, ram_data_a, ram_addrb, merge_ready});
        end
      end
    end
    tests_run++;
    if (mem[9] !== 8'd8 || exp_wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_table: got p9=%0d pending %0d, required p9=8 pending 0", mem[9], exp_wr_q.size());
    end
    exp_wr_q.push_back({8'd4, 8'd2});
    exp_wr_q.push_back({8'd5, 8'd3});
    exp_wr_q.push_back({8'd6, 8'd2});
    exp_wr_q.push_back({8'd7, 8'd3});
    exp_wr_q.push_back({8'd8, 8'd1});
    exp_wr_q.push_back({8'd9, 8'd1});
    exp_wr_q.push_back({8'd10, 8'd1});
    exp_wr_q.push_back({8'd11, 8'd1});
    drive_flatten(8'd11, 80, rdy0, dc, dn, ic, st);
    tests_run++;
    if (dc != 47 || dn != 1 || ic != 48) begin
      tests_failed++;
      $display("FAIL reflat_timing: got done cycle %0d count %0d idle %0d, required 47 1 48", dc, dn, ic);
    end
    tests_run++;
    if (mem[9] !== 8'd1 || mem[11] !== 8'd1 || mem[6] !== 8'd2 || exp_wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reflat_table: got p9=%0d p11=%0d p6=%0d pending %0d, required 1 1 2 0",
               mem[9], mem[11], mem[6], exp_wr_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    // Zero table: link 5->3, then 7->3 via 5's chain, then no-ops, then fresh links.
    mq.push_back(mk(8'd5, 8'd3, 32'h0000_000A,  5, 6, 8'd5, 8'd3));
    mq.push_back(mk(8'd7, 8'd5, 32'h0000_002A,  7, 8, 8'd7, 8'd3));
    mq.push_back(mk(8'd4, 8'd4, 32'h0000_0000, -1, 1, 8'd0, 8'd0));
    mq.push_back(mk(8'd0, 8'd9, 32'h0000_0000, -1, 1, 8'd0, 8'd0));
    mq.push_back(mk(8'd5, 8'd3, 32'h0000_002A, -1, 8, 8'd0, 8'd0));
    mq.push_back(mk(8'd6, 8'd4, 32'h0000_000A,  5, 6, 8'd6, 8'd4));
    mq.push_back(mk(8'd4, 8'd2, 32'h0000_000A,  5, 6, 8'd4, 8'd2));
    test_merges();
    test_flatten_full();
    test_flatten_empty();
    test_reset_mid_flatten();
    tests_run++;
    if (exp_wr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_pending: got %0d writes outstanding, required 0", exp_wr_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
